// File: rtl/cond_unit.sv
// ARM-style condition unit: evaluates Cond against the stored NZVC flags, gates the
// write strobes, updates the flags, and counts executed and squashed instructions.
`timescale 1ns/1ps
module cond_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    input  logic        clr_cnt,
    output logic        CondEx,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  Flags,
    output logic [15:0] exec_cnt,
    output logic [15:0] skip_cnt
);

    logic [3:0]  flags_q;
    logic [15:0] exec_q;
    logic [15:0] skip_q;
    logic        n, z, v, c;
    logic        cond_pass;

    assign {n, z, v, c} = flags_q;

    // Evaluated on the stored flags only, so this cycle's ALU result cannot affect itself.
    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~(c & ~z);
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = ~(~z & (n == v));
            default: cond_pass = 1'b1;
        endcase
    end

    assign CondEx   = valid & cond_pass;
    assign PCSrc    = PCS  & CondEx;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;
    assign Flags    = flags_q;
    assign exec_cnt = exec_q;
    assign skip_cnt = skip_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else begin
            if (CondEx && FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (CondEx && FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Saturating counters; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_q <= 16'd0;
            skip_q <= 16'd0;
        end else if (clr_cnt) begin
            exec_q <= 16'd0;
            skip_q <= 16'd0;
        end else if (valid) begin
            if (CondEx) begin
                if (exec_q != 16'hFFFF) exec_q <= exec_q + 16'd1;
            end else begin
                if (skip_q != 16'hFFFF) skip_q <= skip_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: driver pushes model expectations, a negedge monitor
// pops and compares against the DUT outputs.
`timescale 1ns/1ps
module tb_cond_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  Cond = 4'd0;
    logic [3:0]  ALUFlags = 4'd0;
    logic [1:0]  FlagW = 2'd0;
    logic        PCS = 1'b0;
    logic        RegW = 1'b0;
    logic        MemW = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        CondEx, PCSrc, RegWrite, MemWrite;
    logic [3:0]  Flags;
    logic [15:0] exec_cnt, skip_cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       condex;
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic [3:0] flags;
        int         exec;
        int         skip;
    } exp_t;

    exp_t q[$];

    // reference state: flags as {N,Z,V,C}, counters as plain integers
    logic [3:0] m_flags = 4'd0;
    int         m_exec = 0;
    int         m_skip = 0;

    cond_unit dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .clr_cnt(clr_cnt),
        .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit cond_holds(logic [3:0] cond, logic [3:0] f);
        bit n, z, v, c, base;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (cond >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    task automatic drive(bit v, logic [3:0] cd, logic [3:0] alu, logic [1:0] fw,
                         bit pcs, bit rw, bit mw, bit clr);
        valid = v; Cond = cd; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; clr_cnt = clr;
    endtask

    // expected outputs for the currently driven inputs, then advance the model past the edge
    task automatic predict_and_step();
        exp_t e;
        bit pass;
        pass = valid && cond_holds(Cond, m_flags);
        e.condex = pass;
        e.pcsrc = PCS && pass;
        e.regwrite = RegW && pass;
        e.memwrite = MemW && pass;
        e.flags = m_flags;
        e.exec = m_exec;
        e.skip = m_skip;
        q.push_back(e);
        if (pass && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
        if (pass && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
        if (clr_cnt) begin
            m_exec = 0;
            m_skip = 0;
        end else if (valid) begin
            if (pass) m_exec = (m_exec + 1 > 65535) ? 65535 : m_exec + 1;
            else      m_skip = (m_skip + 1 > 65535) ? 65535 : m_skip + 1;
        end
    endtask

    task automatic cycle(bit v, logic [3:0] cd, logic [3:0] alu, logic [1:0] fw,
                         bit pcs, bit rw, bit mw, bit clr);
        @(posedge clk);
        #1;
        drive(v, cd, alu, fw, pcs, rw, mw, clr);
        predict_and_step();
    endtask

    // reset pulsed low between edges; outputs observed while it is low, released before the next edge
    task automatic reset_cycle(bit v, logic [3:0] cd, logic [3:0] alu, logic [1:0] fw,
                               bit pcs, bit rw, bit mw, bit clr);
        @(posedge clk);
        #1;
        drive(v, cd, alu, fw, pcs, rw, mw, clr);
        reset_n = 1'b0;
        #1;
        m_flags = 4'd0;
        m_exec = 0;
        m_skip = 0;
        predict_and_step();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("CondEx",   int'(CondEx),   int'(e.condex));
            chk("PCSrc",    int'(PCSrc),    int'(e.pcsrc));
            chk("RegWrite", int'(RegWrite), int'(e.regwrite));
            chk("MemWrite", int'(MemWrite), int'(e.memwrite));
            chk("Flags",    int'(Flags),    int'(e.flags));
            chk("exec_cnt", int'(exec_cnt), e.exec);
            chk("skip_cnt", int'(skip_cnt), e.skip);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        // reset state, then EQ on cleared flags is squashed and counted as skipped
        reset_cycle(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        cycle(1, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0);
        // AL with flag write: gated write same cycle, flags visible next cycle
        cycle(1, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 0);
        cycle(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
        // failed NE must not write memory or flags
        cycle(1, 4'b0001, 4'b1010, 2'b11, 0, 0, 1, 0);
        cycle(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        // GE / HI boundary cases
        cycle(1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0);
        cycle(1, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0);
        cycle(1, 4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0);
        cycle(1, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0);
        cycle(1, 4'b1110, 4'b0101, 2'b11, 0, 0, 0, 0);
        cycle(1, 4'b1000, 4'b0000, 2'b00, 1, 1, 1, 0);
        // partial flag writes
        cycle(1, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0);
        cycle(1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0);
        cycle(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        // EQ/NE/GE/AL after reset
        reset_cycle(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        cycle(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0);
        cycle(1, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0);
        cycle(1, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0);
        cycle(1, 4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0);
        // reset mid-operation with flags 1111 and nonzero counters
        cycle(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
        cycle(1, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0);
        reset_cycle(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        cycle(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 31) == 0);
        end
        // saturation of exec_cnt, then clear with a valid AL in the same cycle
        cycle(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 1);
        for (int i = 0; i < 65534; i++) begin
            cycle(1, 4'b1110, 4'($urandom), 2'($urandom), 0, 1, 0, 0);
        end
        repeat (3) cycle(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        cycle(1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 1);
        cycle(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: valid  input  1  instruction present this cycle.
REQ-004 SHALL have port: Cond  input  4  ARM condition field, instruction bits [31:28].
REQ-005 SHALL have port: ALUFlags  input  4  ALU flags {N,Z,V,C} for the current instruction.
REQ-006 SHALL have port: FlagW  input  2  flag write request; [1] writes N,Z; [0] writes V,C.
REQ-007 SHALL have port: PCS  input  1  ungated PC-write request.
REQ-008 SHALL have port: RegW  input  1  ungated register-write request.
REQ-009 SHALL have port: MemW  input  1  ungated memory-write request.
REQ-010 SHALL have port: clr_cnt  input  1  synchronous counter clear.
REQ-011 SHALL have port: CondEx  output  1  condition passed for the current instruction.
REQ-012 SHALL have port: PCSrc  output  1  gated PC write.
REQ-013 SHALL have port: RegWrite  output  1  gated register write.
REQ-014 SHALL have port: MemWrite  output  1  gated memory write.
REQ-015 SHALL have port: Flags  output  4  stored {N,Z,V,C}.
REQ-016 SHALL have port: exec_cnt  output  16  executed-instruction count.
REQ-017 SHALL have port: skip_cnt  output  16  squashed-instruction count.

Function
REQ-018 SHALL hold a 4-bit flag register {N,Z,V,C}, driven directly on Flags.
REQ-019 SHALL compute CondEx combinationally from Cond and the stored flags only (previous instruction's flags), never from ALUFlags.
REQ-020 SHALL decode Cond as: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~(C&~Z); 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 ~(~Z&(N==V)); 1110 1; 1111 1.
REQ-021 SHALL force CondEx to 0 when valid=0.
REQ-022 SHALL drive PCSrc=PCS&CondEx, RegWrite=RegW&CondEx, MemWrite=MemW&CondEx, all combinational and zero-latency.
REQ-023 SHALL, on a rising clk edge with CondEx=1 and FlagW[1]=1, load N,Z from ALUFlags[3:2].
REQ-024 SHALL, on a rising clk edge with CondEx=1 and FlagW[0]=1, load V,C from ALUFlags[1:0].
REQ-025 SHALL leave each flag pair unchanged when its FlagW bit is 0 or CondEx=0; a failed instruction never updates flags.
REQ-026 SHALL make updated flags visible to the next cycle's condition evaluation (one-cycle flag latency); same-cycle update and evaluation use the pre-update value.
REQ-027 SHALL increment exec_cnt on each edge with valid=1 and CondEx=1, and skip_cnt on each edge with valid=1 and CondEx=0.
REQ-028 SHALL saturate both counters at 0xFFFF; no wrap-around.
REQ-029 SHALL clear both counters to 0 on an edge with clr_cnt=1; clr_cnt has priority over increment in the same cycle; clr_cnt does not affect flags.

Reset
REQ-030 SHALL, while reset_n=0, immediately set flags to 0000 and both counters to 0, independent of clk.
REQ-031 SHALL, with reset flags 0000, yield CondEx=0 for EQ and CondEx=1 for NE, GE and AL.
REQ-032 SHALL, on reset asserted mid-operation, discard any pending flag update or count from that cycle.

Verification
REQ-033 SHALL verify: reset, then Cond=0000, valid=1 -> CondEx=0, exec_cnt=0, skip_cnt increments to 1 after the edge.
REQ-034 SHALL verify: Cond=1110, FlagW=11, ALUFlags=0100, RegW=1 -> RegWrite=1 same cycle; Flags=0100 next cycle; Cond=0000 then gives CondEx=1.
REQ-035 SHALL verify: Flags=0100, Cond=0001, FlagW=11, ALUFlags=1010 -> CondEx=0, MemWrite=0, Flags remain 0100.
REQ-036 SHALL verify: Flags=1000, Cond=1010 -> CondEx=0; Flags=1010, Cond=1010 -> CondEx=1; Flags=0101, Cond=1000 -> CondEx=0.
REQ-037 SHALL verify: exec_cnt preloaded to 0xFFFE, two AL instructions -> 0xFFFF and held; clr_cnt=1 with valid AL -> exec_cnt=0.
REQ-038 SHALL verify: reset_n pulsed low between edges with Flags=1111 and counters nonzero -> Flags=0000 and counters=0 before the next edge.
